aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule generator. Sits directly upstream of the round-key XOR stage.
//  - Accepts one 128-bit cipher key.
//  - Emits round keys 0..10 in order, one per accepted beat, over a valid/ready stream.
//  - The round datapath consumes each key on key_i of the XOR stage.
//  - Each round key is computed from the previous one: no 176-byte key store.

---
 rtl/aes_key_expand.sv | 168 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule.
// Holds only the current round key and rcon. Each accepted beat derives the
// next round key from the one just emitted. No full key store is kept.
// Round keys 0..NR leave on a valid/ready stream that never retracts a beat.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic [127:0] key_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    output logic [127:0] rkey_o,
    output logic [3:0]   rkey_round_o,
    output logic         rkey_valid_o,
    input  logic         rkey_ready_i
);

    // The schedule below (rcon run, round counter width) only covers AES-128.
    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_key_expand: NR must be 10 (AES-128 only)");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The field polynomial is x^8 + x^4 + x^3 + x + 1.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Computes the multiplicative inverse as x^254 with an addition chain.
    // The chain maps 0 to 0, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Forward S-box: field inverse followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;

    logic         w_key_take;
    logic         w_rkey_hs;
    logic         w_last;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;

    assign w_key_take = (r_state == S_IDLE) && key_valid_i && !clear_i;
    assign w_rkey_hs  = (r_state == S_OUT) && rkey_ready_i && !clear_i;
    assign w_last     = (r_round == LAST_ROUND);

    // Next round key from the current one: one SubWord/RotWord and a chain of XORs.
    always_comb begin
        w_w0 = r_key[127:96];
        w_w1 = r_key[95:64];
        w_w2 = r_key[63:32];
        w_w3 = r_key[31:0];
        w_t  = sub_word({w_w3[23:0], w_w3[31:24]}) ^ {r_rcon, 24'h000000};
        w_n0 = w_w0 ^ w_t;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. clear_i wins over both handshakes.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_key_take) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (clear_i)                   w_state_nxt = S_IDLE;
                else if (w_rkey_hs && w_last)  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key, round and rcon registers. They advance only on a consumed beat,
    // so an unaccepted round key holds steady.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= 8'h01;
        end else if (clear_i) begin
            r_round <= '0;
            r_rcon  <= 8'h01;
        end else if (w_key_take) begin
            r_key   <= key_i;
            r_round <= '0;
            r_rcon  <= 8'h01;
        end else if (w_rkey_hs && !w_last) begin
            r_key   <= w_next_key;
            r_round <= r_round + 4'd1;
            r_rcon  <= xtime(r_rcon);
        end
    end

    assign key_ready_o  = (r_state == S_IDLE);
    assign rkey_valid_o = (r_state == S_OUT);
    assign rkey_o       = r_key;
    assign rkey_round_o = r_round;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand.
// A reference schedule is built from FIPS-197 rules: a brute-force S-box and
// a word-array expansion. A transaction-level model predicts the stream on
// every cycle. A scoreboard also collects the beats the DUT actually handed
// over and compares them with the reference schedule.
module tb_aes_key_expand;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         key_valid_i = 1'b0;
    logic         key_ready_o;
    logic [127:0] rkey_o;
    logic [3:0]   rkey_round_o;
    logic         rkey_valid_o;
    logic         rkey_ready_i = 1'b0;

    aes_key_expand #(.NR(10)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .key_i        (key_i),
        .key_valid_i  (key_valid_i),
        .key_ready_o  (key_ready_o),
        .rkey_o       (rkey_o),
        .rkey_round_o (rkey_round_o),
        .rkey_valid_o (rkey_valid_o),
        .rkey_ready_i (rkey_ready_i)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0R1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K0R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] k;
    } beat_t;
    beat_t q_dut [$];

    // Reference model state
    bit                 m_idle = 1'b1;
    int                 m_idx  = 0;
    bit                 m_zero = 1'b1;
    logic [10:0][127:0] m_sched;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Polynomial product followed by reduction mod 0x11B.
    function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [10:0][127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = pmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int j = 0; j < 11; j++) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
        return r;
    endfunction

    // An asynchronous reset wipes the model immediately, even between clock edges.
    always @(negedge rst_ni) begin
        m_idle = 1'b1;
        m_idx  = 0;
        m_zero = 1'b1;
    end

    // Per-cycle compare against the model, then advance the model using the
    // inputs that the coming rising edge will sample.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_idle = 1'b1;
            m_idx  = 0;
            m_zero = 1'b1;
        end
        chk("key_ready_o", 128'(key_ready_o), 128'(m_idle));
        chk("rkey_valid_o", 128'(rkey_valid_o), 128'(!m_idle));
        if (!m_idle) begin
            chk("rkey_o", rkey_o, m_sched[m_idx]);
            chk("rkey_round_o", 128'(rkey_round_o), 128'(m_idx));
        end else if (m_zero) begin
            chk("rkey_o_reset", rkey_o, 128'h0);
            chk("rkey_round_o_reset", 128'(rkey_round_o), 128'h0);
        end
        if (rst_ni && !clear_i && rkey_valid_o && rkey_ready_i)
            q_dut.push_back('{rnd: rkey_round_o, k: rkey_o});
        if (rst_ni) begin
            if (clear_i) begin
                m_idle = 1'b1;
                m_idx  = 0;
                m_zero = 1'b0;
            end else if (m_idle && key_valid_i) begin
                m_idle  = 1'b0;
                m_idx   = 0;
                m_zero  = 1'b0;
                m_sched = expand(key_i);
            end else if (!m_idle && rkey_ready_i) begin
                if (m_idx == 10) m_idle = 1'b1;
                else             m_idx  = m_idx + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Holds key_valid_i until a rising edge actually takes the key.
    task automatic send_key(input logic [127:0] k);
        bit acc;
        acc = 1'b0;
        key_i = k;
        key_valid_i = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = key_ready_o && !clear_i;
            step();
        end
        key_valid_i = 1'b0;
        chk("send_key_accepted", 128'(acc), 128'h1);
    endtask

    task automatic wait_idle(input bit rand_rdy);
        bit done;
        done = key_ready_o;
        for (int i = 0; i < 400 && !done; i++) begin
            if (rand_rdy) rkey_ready_i = 1'($urandom_range(0, 1));
            step();
            done = key_ready_o;
        end
        chk("wait_idle", 128'(done), 128'h1);
    endtask

    task automatic check_stream(input string name, input logic [127:0] k);
        logic [10:0][127:0] e;
        e = expand(k);
        chk({name, "_beats"}, 128'(q_dut.size()), 128'd11);
        for (int i = 0; i < q_dut.size() && i < 11; i++) begin
            chk({name, "_round"}, 128'(q_dut[i].rnd), 128'(i));
            chk({name, "_key"}, q_dut[i].k, e[i]);
        end
        q_dut.delete();
    endtask

    initial begin
        logic [10:0][127:0] e;
        logic [127:0]       kr;
        logic [127:0]       kb;

        build_sbox();
        // Pin the reference model to published values.
        chk("model_sbox_00", 128'(sb[0]), 128'h63);
        chk("model_sbox_01", 128'(sb[1]), 128'h7C);
        e = expand(K1);
        chk("model_k1_r0", e[0], K1);
        chk("model_k1_r1", e[1], K1R1);
        chk("model_k1_r10", e[10], K1R10);
        e = expand(128'h0);
        chk("model_k0_r1", e[1], K0R1);
        chk("model_k0_r10", e[10], K0R10);

        // Reset
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        step();

        // Test 1: FIPS vector with no backpressure, plus exact cycle timing.
        rkey_ready_i = 1'b1;
        send_key(K1);
        chk("t1_r0", rkey_o, K1);
        step();
        chk("t1_r1", rkey_o, K1R1);
        repeat (9) step();
        chk("t1_r10", rkey_o, K1R10);
        chk("t1_r10_round", 128'(rkey_round_o), 128'd10);
        step();
        chk("t1_ready_n12", 128'(key_ready_o), 128'h1);
        chk("t1_valid_drop", 128'(rkey_valid_o), 128'h0);
        check_stream("t1", K1);

        // Test 2: all-zero key.
        send_key(128'h0);
        step();
        chk("t2_r1", rkey_o, K0R1);
        repeat (9) step();
        chk("t2_r10", rkey_o, K0R10);
        wait_idle(1'b0);
        check_stream("t2", 128'h0);

        // Test 3: random backpressure, first on the FIPS key and then on random keys.
        rkey_ready_i = 1'b0;
        send_key(K1);
        wait_idle(1'b1);
        rkey_ready_i = 1'b1;
        check_stream("t3", K1);
        for (int n = 0; n < 4; n++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            rkey_ready_i = 1'b0;
            send_key(kr);
            wait_idle(1'b1);
            rkey_ready_i = 1'b1;
            check_stream("t3_rand", kr);
        end

        // Test 4: a second key offered while busy waits until IDLE.
        kb = {$urandom, $urandom, $urandom, $urandom};
        send_key(K1);
        repeat (3) step();
        send_key(kb);
        check_stream("t4_first", K1);
        chk("t4_second_r0", rkey_o, kb);
        wait_idle(1'b0);
        check_stream("t4_second", kb);

        // Test 5: clear while round 4 is pending, and clear with a key in IDLE.
        send_key(K1);
        repeat (4) step();
        chk("t5_round4", 128'(rkey_round_o), 128'd4);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t5_valid_after_clear", 128'(rkey_valid_o), 128'h0);
        chk("t5_ready_after_clear", 128'(key_ready_o), 128'h1);
        q_dut.delete();
        key_i = kb;
        key_valid_i = 1'b1;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        key_valid_i = 1'b0;
        chk("t5_clear_blocks_key", 128'(key_ready_o), 128'h1);
        send_key(K1);
        step();
        chk("t5_restart_r1", rkey_o, K1R1);
        wait_idle(1'b0);
        check_stream("t5", K1);

        // Test 6: an asynchronous reset pulse during round 7, then a replay.
        send_key(K1);
        repeat (7) step();
        #5 rst_ni = 1'b0;
        #1;
        chk("t6_ready_async", 128'(key_ready_o), 128'h1);
        chk("t6_valid_async", 128'(rkey_valid_o), 128'h0);
        chk("t6_rkey_async", rkey_o, 128'h0);
        chk("t6_round_async", 128'(rkey_round_o), 128'h0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        q_dut.delete();
        step();
        send_key(K1);
        wait_idle(1'b0);
        check_stream("t6_replay", K1);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
